// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the LSU memory switch: tag bit positions,
// response source encoding and request-buffer state encoding.
package lsu_mem_pkg;

    localparam int TAG_SM_BIT = 0;
    localparam int TAG_NC_BIT = 1;

    typedef enum logic {
        SRC_CACHE = 1'b0,
        SRC_SMEM  = 1'b1
    } rsp_src_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/lsu_elastic_buf.sv
// Two-entry elastic buffer with registered outputs. Handshake: a transfer
// happens on a side in any cycle where both valid and ready are high there.
module lsu_elastic_buf
    import lsu_mem_pkg::*;
#(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [DATAW-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [DATAW-1:0] out_data_o,
    input  logic             out_ready_i,
    output buf_state_t       state_o
);

    buf_state_t       state_q;
    logic [DATAW-1:0] head_q;
    logic [DATAW-1:0] tail_q;
    logic             push;
    logic             pop;

    assign in_ready_o  = (state_q != BUF_FULL);
    assign out_valid_o = (state_q != BUF_EMPTY);
    assign out_data_o  = head_q;
    assign state_o     = state_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // head_q always holds the oldest entry; tail_q is only live in FULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        head_q  <= in_data_i;
                        state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        head_q <= in_data_i;
                    end else if (push) begin
                        tail_q  <= in_data_i;
                        state_q <= BUF_FULL;
                    end else if (pop) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= BUF_ONE;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_switch.sv
// Per-lane steering of LSU requests to shared memory or D$ by tag[0], and a
// round-robin merge of the two response streams into one registered port.
module lsu_mem_switch
    import lsu_mem_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_LANES-1:0]                  lsu_req_valid_i,
    input  logic [NUM_LANES-1:0]                  lsu_req_rw_i,
    input  logic [NUM_LANES-1:0][ADDR_W-1:0]      lsu_req_addr_i,
    input  logic [NUM_LANES-1:0][DATA_W/8-1:0]    lsu_req_byteen_i,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]      lsu_req_data_i,
    input  logic [NUM_LANES-1:0][TAG_W-1:0]       lsu_req_tag_i,
    output logic [NUM_LANES-1:0]                  lsu_req_ready_o,
    output logic [NUM_LANES-1:0]                  cache_req_valid_o,
    output logic [NUM_LANES-1:0]                  cache_req_rw_o,
    output logic [NUM_LANES-1:0][ADDR_W-1:0]      cache_req_addr_o,
    output logic [NUM_LANES-1:0][DATA_W/8-1:0]    cache_req_byteen_o,
    output logic [NUM_LANES-1:0][DATA_W-1:0]      cache_req_data_o,
    output logic [NUM_LANES-1:0][TAG_W-1:0]       cache_req_tag_o,
    input  logic [NUM_LANES-1:0]                  cache_req_ready_i,
    output logic [NUM_LANES-1:0]                  smem_req_valid_o,
    output logic [NUM_LANES-1:0]                  smem_req_rw_o,
    output logic [NUM_LANES-1:0][ADDR_W-1:0]      smem_req_addr_o,
    output logic [NUM_LANES-1:0][DATA_W/8-1:0]    smem_req_byteen_o,
    output logic [NUM_LANES-1:0][DATA_W-1:0]      smem_req_data_o,
    output logic [NUM_LANES-1:0][TAG_W-1:0]       smem_req_tag_o,
    input  logic [NUM_LANES-1:0]                  smem_req_ready_i,
    input  logic                                  cache_rsp_valid_i,
    input  logic [NUM_LANES-1:0]                  cache_rsp_tmask_i,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]      cache_rsp_data_i,
    input  logic [TAG_W-1:0]                      cache_rsp_tag_i,
    output logic                                  cache_rsp_ready_o,
    input  logic                                  smem_rsp_valid_i,
    input  logic [NUM_LANES-1:0]                  smem_rsp_tmask_i,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]      smem_rsp_data_i,
    input  logic [TAG_W-1:0]                      smem_rsp_tag_i,
    output logic                                  smem_rsp_ready_o,
    output logic                                  lsu_rsp_valid_o,
    output logic [NUM_LANES-1:0]                  lsu_rsp_tmask_o,
    output logic [NUM_LANES-1:0][DATA_W-1:0]      lsu_rsp_data_o,
    output logic [TAG_W-1:0]                      lsu_rsp_tag_o,
    input  logic                                  lsu_rsp_ready_i,
    output buf_state_t [NUM_LANES-1:0]            dbg_cache_state_o,
    output buf_state_t [NUM_LANES-1:0]            dbg_smem_state_o,
    output rsp_src_t                              dbg_rsp_prio_o
);

    localparam int REQ_W = 1 + ADDR_W + DATA_W/8 + DATA_W + TAG_W;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic             to_smem;
        logic             cache_in_rdy;
        logic             smem_in_rdy;
        logic [REQ_W-1:0] req_pl;
        logic [REQ_W-1:0] cache_pl;
        logic [REQ_W-1:0] smem_pl;

        assign to_smem = lsu_req_tag_i[i][TAG_SM_BIT];
        assign req_pl  = {lsu_req_rw_i[i], lsu_req_addr_i[i], lsu_req_byteen_i[i],
                          lsu_req_data_i[i], lsu_req_tag_i[i]};

        lsu_elastic_buf #(.DATAW(REQ_W)) u_cache_buf (
            .clk         (clk),
            .reset       (reset),
            .in_valid_i  (lsu_req_valid_i[i] && !to_smem),
            .in_data_i   (req_pl),
            .in_ready_o  (cache_in_rdy),
            .out_valid_o (cache_req_valid_o[i]),
            .out_data_o  (cache_pl),
            .out_ready_i (cache_req_ready_i[i]),
            .state_o     (dbg_cache_state_o[i])
        );

        lsu_elastic_buf #(.DATAW(REQ_W)) u_smem_buf (
            .clk         (clk),
            .reset       (reset),
            .in_valid_i  (lsu_req_valid_i[i] && to_smem),
            .in_data_i   (req_pl),
            .in_ready_o  (smem_in_rdy),
            .out_valid_o (smem_req_valid_o[i]),
            .out_data_o  (smem_pl),
            .out_ready_i (smem_req_ready_i[i]),
            .state_o     (dbg_smem_state_o[i])
        );

        // Only the routing bit reaches ready combinationally; buffer readiness is registered.
        assign lsu_req_ready_o[i] = to_smem ? smem_in_rdy : cache_in_rdy;

        assign {cache_req_rw_o[i], cache_req_addr_o[i], cache_req_byteen_o[i],
                cache_req_data_o[i], cache_req_tag_o[i]} = cache_pl;
        assign {smem_req_rw_o[i], smem_req_addr_o[i], smem_req_byteen_o[i],
                smem_req_data_o[i], smem_req_tag_o[i]} = smem_pl;
    end

    logic                             rsp_valid_q, rsp_valid_d;
    logic [NUM_LANES-1:0]             rsp_tmask_q, rsp_tmask_d;
    logic [NUM_LANES-1:0][DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]                 rsp_tag_q, rsp_tag_d;
    rsp_src_t                         prio_q, prio_d;
    logic                             rsp_take;
    logic                             gnt_cache;
    logic                             gnt_smem;

    // Grants are suppressed in reset so no source is acked without capture.
    always_comb begin
        rsp_take  = !rsp_valid_q || lsu_rsp_ready_i;
        gnt_cache = !reset && rsp_take && cache_rsp_valid_i &&
                    (!smem_rsp_valid_i || prio_q == SRC_CACHE);
        gnt_smem  = !reset && rsp_take && smem_rsp_valid_i &&
                    (!cache_rsp_valid_i || prio_q == SRC_SMEM);

        rsp_valid_d = rsp_valid_q;
        rsp_tmask_d = rsp_tmask_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        prio_d      = prio_q;

        if (rsp_take) begin
            rsp_valid_d = gnt_cache || gnt_smem;
        end
        if (gnt_cache) begin
            rsp_tmask_d = cache_rsp_tmask_i;
            rsp_data_d  = cache_rsp_data_i;
            rsp_tag_d   = cache_rsp_tag_i;
        end else if (gnt_smem) begin
            rsp_tmask_d = smem_rsp_tmask_i;
            rsp_data_d  = smem_rsp_data_i;
            rsp_tag_d   = smem_rsp_tag_i;
        end
        if (cache_rsp_valid_i && smem_rsp_valid_i && rsp_take) begin
            prio_d = gnt_cache ? SRC_SMEM : SRC_CACHE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_tmask_q <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            prio_q      <= SRC_CACHE;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_tmask_q <= rsp_tmask_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            prio_q      <= prio_d;
        end
    end

    assign cache_rsp_ready_o = gnt_cache;
    assign smem_rsp_ready_o  = gnt_smem;
    assign lsu_rsp_valid_o   = rsp_valid_q;
    assign lsu_rsp_tmask_o   = rsp_tmask_q;
    assign lsu_rsp_data_o    = rsp_data_q;
    assign lsu_rsp_tag_o     = rsp_tag_q;
    assign dbg_rsp_prio_o    = prio_q;

endmodule

// File: tb/tb_lsu_mem_switch.sv
// Directed bench for lsu_mem_switch: request routing, backpressure, response
// arbitration/hold and mid-operation reset, each step with fixed expectations.
module tb_lsu_mem_switch;
    import lsu_mem_pkg::*;

    localparam int NL = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NL-1:0]        lsu_req_valid, lsu_req_rw, lsu_req_ready;
    logic [NL-1:0][AW-1:0]   lsu_req_addr;
    logic [NL-1:0][DW/8-1:0] lsu_req_byteen;
    logic [NL-1:0][DW-1:0]   lsu_req_data;
    logic [NL-1:0][TW-1:0]   lsu_req_tag;
    logic [NL-1:0]        cache_req_valid, cache_req_rw, cache_req_ready;
    logic [NL-1:0][AW-1:0]   cache_req_addr;
    logic [NL-1:0][DW/8-1:0] cache_req_byteen;
    logic [NL-1:0][DW-1:0]   cache_req_data;
    logic [NL-1:0][TW-1:0]   cache_req_tag;
    logic [NL-1:0]        smem_req_valid, smem_req_rw, smem_req_ready;
    logic [NL-1:0][AW-1:0]   smem_req_addr;
    logic [NL-1:0][DW/8-1:0] smem_req_byteen;
    logic [NL-1:0][DW-1:0]   smem_req_data;
    logic [NL-1:0][TW-1:0]   smem_req_tag;
    logic                 cache_rsp_valid, cache_rsp_ready;
    logic [NL-1:0]        cache_rsp_tmask;
    logic [NL-1:0][DW-1:0] cache_rsp_data;
    logic [TW-1:0]        cache_rsp_tag;
    logic                 smem_rsp_valid, smem_rsp_ready;
    logic [NL-1:0]        smem_rsp_tmask;
    logic [NL-1:0][DW-1:0] smem_rsp_data;
    logic [TW-1:0]        smem_rsp_tag;
    logic                 lsu_rsp_valid, lsu_rsp_ready;
    logic [NL-1:0]        lsu_rsp_tmask;
    logic [NL-1:0][DW-1:0] lsu_rsp_data;
    logic [TW-1:0]        lsu_rsp_tag;
    buf_state_t [NL-1:0]  dbg_cache_state, dbg_smem_state;
    rsp_src_t             dbg_rsp_prio;

    int checks = 0;
    int errors = 0;

    lsu_mem_switch #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk                (clk),
        .reset              (reset),
        .lsu_req_valid_i    (lsu_req_valid),
        .lsu_req_rw_i       (lsu_req_rw),
        .lsu_req_addr_i     (lsu_req_addr),
        .lsu_req_byteen_i   (lsu_req_byteen),
        .lsu_req_data_i     (lsu_req_data),
        .lsu_req_tag_i      (lsu_req_tag),
        .lsu_req_ready_o    (lsu_req_ready),
        .cache_req_valid_o  (cache_req_valid),
        .cache_req_rw_o     (cache_req_rw),
        .cache_req_addr_o   (cache_req_addr),
        .cache_req_byteen_o (cache_req_byteen),
        .cache_req_data_o   (cache_req_data),
        .cache_req_tag_o    (cache_req_tag),
        .cache_req_ready_i  (cache_req_ready),
        .smem_req_valid_o   (smem_req_valid),
        .smem_req_rw_o      (smem_req_rw),
        .smem_req_addr_o    (smem_req_addr),
        .smem_req_byteen_o  (smem_req_byteen),
        .smem_req_data_o    (smem_req_data),
        .smem_req_tag_o     (smem_req_tag),
        .smem_req_ready_i   (smem_req_ready),
        .cache_rsp_valid_i  (cache_rsp_valid),
        .cache_rsp_tmask_i  (cache_rsp_tmask),
        .cache_rsp_data_i   (cache_rsp_data),
        .cache_rsp_tag_i    (cache_rsp_tag),
        .cache_rsp_ready_o  (cache_rsp_ready),
        .smem_rsp_valid_i   (smem_rsp_valid),
        .smem_rsp_tmask_i   (smem_rsp_tmask),
        .smem_rsp_data_i    (smem_rsp_data),
        .smem_rsp_tag_i     (smem_rsp_tag),
        .smem_rsp_ready_o   (smem_rsp_ready),
        .lsu_rsp_valid_o    (lsu_rsp_valid),
        .lsu_rsp_tmask_o    (lsu_rsp_tmask),
        .lsu_rsp_data_o     (lsu_rsp_data),
        .lsu_rsp_tag_o      (lsu_rsp_tag),
        .lsu_rsp_ready_i    (lsu_rsp_ready),
        .dbg_cache_state_o  (dbg_cache_state),
        .dbg_smem_state_o   (dbg_smem_state),
        .dbg_rsp_prio_o     (dbg_rsp_prio)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset           = 1'b1;
        lsu_req_valid   = '0;
        lsu_req_rw      = '0;
        lsu_req_addr    = '0;
        lsu_req_byteen  = '1;
        lsu_req_data    = '0;
        lsu_req_tag     = '0;
        cache_req_ready = '1;
        smem_req_ready  = '1;
        cache_rsp_valid = 1'b0;
        cache_rsp_tmask = '0;
        cache_rsp_data  = '0;
        cache_rsp_tag   = '0;
        smem_rsp_valid  = 1'b0;
        smem_rsp_tmask  = '0;
        smem_rsp_data   = '0;
        smem_rsp_tag    = '0;
        lsu_rsp_ready   = 1'b1;

        // Reset: response sources must not be acknowledged while reset is high.
        tick();
        cache_rsp_valid = 1'b1;
        smem_rsp_valid  = 1'b1;
        #1;
        chk("rst_cache_rsp_ready", cache_rsp_ready, 1'b0);
        chk("rst_smem_rsp_ready", smem_rsp_ready, 1'b0);
        tick();
        cache_rsp_valid = 1'b0;
        smem_rsp_valid  = 1'b0;
        chk("rst_cache_req_valid", cache_req_valid, 4'b0000);
        chk("rst_smem_req_valid", smem_req_valid, 4'b0000);
        chk("rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        chk("rst_prio", dbg_rsp_prio, SRC_CACHE);
        reset = 1'b0;
        tick();
        chk("post_rst_req_ready", lsu_req_ready, 4'b1111);
        chk("post_rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);

        // Routing: lane 0 to smem, lane 1 to cache, one-cycle latency.
        lsu_req_valid   = 4'b0011;
        lsu_req_addr[0] = 30'h100;
        lsu_req_tag[0]  = 16'h0001;
        lsu_req_data[0] = 32'hAAAA_0000;
        lsu_req_addr[1] = 30'h200;
        lsu_req_tag[1]  = 16'h0000;
        lsu_req_data[1] = 32'hBBBB_1111;
        lsu_req_rw      = 4'b0010;
        tick();
        lsu_req_valid = '0;
        chk("route_smem_valid", smem_req_valid, 4'b0001);
        chk("route_cache_valid", cache_req_valid, 4'b0010);
        chk("route_smem_addr0", smem_req_addr[0], 30'h100);
        chk("route_cache_addr1", cache_req_addr[1], 30'h200);
        chk("route_smem_tag0", smem_req_tag[0], 16'h0001);
        chk("route_cache_tag1", cache_req_tag[1], 16'h0000);
        chk("route_cache_data1", cache_req_data[1], 32'hBBBB_1111);
        chk("route_cache_rw1", cache_req_rw[1], 1'b1);
        tick();
        chk("route_drained_smem", smem_req_valid, 4'b0000);
        chk("route_drained_cache", cache_req_valid, 4'b0000);

        // Backpressure on cache lanes 2 and 3; lane 3 then issues an smem request.
        cache_req_ready = 4'b0011;
        lsu_req_rw      = '0;
        lsu_req_valid   = 4'b1100;
        lsu_req_tag[2]  = 16'h0000;
        lsu_req_tag[3]  = 16'h0000;
        lsu_req_addr[2] = 30'h2A0;
        lsu_req_addr[3] = 30'h3A0;
        tick();
        chk("bp_first_valid", cache_req_valid, 4'b1100);
        chk("bp_first_state2", dbg_cache_state[2], BUF_ONE);
        lsu_req_addr[2] = 30'h2A1;
        lsu_req_addr[3] = 30'h3A1;
        tick();
        lsu_req_addr[2] = 30'h2A2;
        #1;
        chk("bp_full_ready", lsu_req_ready, 4'b0011);
        chk("bp_full_state2", dbg_cache_state[2], BUF_FULL);
        lsu_req_tag[3]  = 16'h0001;
        lsu_req_addr[3] = 30'h3B0;
        #1;
        chk("bp_lane3_smem_ready", lsu_req_ready, 4'b1011);
        tick();
        lsu_req_valid = 4'b0100;
        chk("bp_lane3_smem_valid", smem_req_valid, 4'b1000);
        chk("bp_lane3_smem_addr", smem_req_addr[3], 30'h3B0);
        chk("bp_lane3_smem_tag", smem_req_tag[3], 16'h0001);
        chk("bp_lane2_head_held", cache_req_addr[2], 30'h2A0);
        cache_req_ready = 4'b0111;
        tick();
        chk("bp_drain1_addr", cache_req_addr[2], 30'h2A1);
        chk("bp_drain1_valid", cache_req_valid[2], 1'b1);
        chk("bp_drain1_ready", lsu_req_ready[2], 1'b1);
        tick();
        lsu_req_valid = '0;
        chk("bp_drain2_addr", cache_req_addr[2], 30'h2A2);
        chk("bp_drain2_state", dbg_cache_state[2], BUF_ONE);
        tick();
        chk("bp_drain3_valid", cache_req_valid[2], 1'b0);
        chk("bp_lane3_cache_held", cache_req_addr[3], 30'h3A0);

        // Both response sources contending for four cycles.
        cache_rsp_valid = 1'b1;
        cache_rsp_tag   = 16'h00C0;
        cache_rsp_tmask = 4'b0101;
        smem_rsp_valid  = 1'b1;
        smem_rsp_tag    = 16'h0051;
        smem_rsp_tmask  = 4'b1010;
        #1;
        chk("rr0_cache_ready", cache_rsp_ready, 1'b1);
        chk("rr0_smem_ready", smem_rsp_ready, 1'b0);
        tick();
        chk("rr0_out_tag", lsu_rsp_tag, 16'h00C0);
        chk("rr0_out_tmask", lsu_rsp_tmask, 4'b0101);
        chk("rr1_cache_ready", cache_rsp_ready, 1'b0);
        chk("rr1_smem_ready", smem_rsp_ready, 1'b1);
        tick();
        chk("rr1_out_tag", lsu_rsp_tag, 16'h0051);
        chk("rr2_cache_ready", cache_rsp_ready, 1'b1);
        tick();
        chk("rr2_out_tag", lsu_rsp_tag, 16'h00C0);
        chk("rr3_smem_ready", smem_rsp_ready, 1'b1);
        tick();
        cache_rsp_valid = 1'b0;
        smem_rsp_valid  = 1'b0;
        chk("rr3_out_tag", lsu_rsp_tag, 16'h0051);
        chk("rr3_out_valid", lsu_rsp_valid, 1'b1);
        tick();
        chk("rr_idle_valid", lsu_rsp_valid, 1'b0);
        chk("rr_prio_back", dbg_rsp_prio, SRC_CACHE);

        // Held response under lsu_rsp_ready=0.
        smem_rsp_valid   = 1'b1;
        smem_rsp_tmask   = 4'b1010;
        smem_rsp_tag     = 16'h0041;
        smem_rsp_data[1] = 32'hDEAD_0041;
        tick();
        chk("hold_capture_tag", lsu_rsp_tag, 16'h0041);
        chk("hold_capture_tmask", lsu_rsp_tmask, 4'b1010);
        chk("hold_capture_data1", lsu_rsp_data[1], 32'hDEAD_0041);
        lsu_rsp_ready    = 1'b0;
        smem_rsp_tag     = 16'h0042;
        smem_rsp_data[1] = 32'hDEAD_0042;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_smem_ready", smem_rsp_ready, 1'b0);
            tick();
            chk("hold_valid", lsu_rsp_valid, 1'b1);
            chk("hold_tag", lsu_rsp_tag, 16'h0041);
            chk("hold_data1", lsu_rsp_data[1], 32'hDEAD_0041);
        end
        lsu_rsp_ready = 1'b1;
        #1;
        chk("release_smem_ready", smem_rsp_ready, 1'b1);
        tick();
        smem_rsp_valid = 1'b0;
        chk("release_next_tag", lsu_rsp_tag, 16'h0042);
        tick();
        chk("release_idle", lsu_rsp_valid, 1'b0);

        // Reset mid-operation: two entries in lane 1 plus a held response.
        cache_req_ready = 4'b0101;
        lsu_req_valid   = 4'b0010;
        lsu_req_tag[1]  = 16'h0000;
        lsu_req_addr[1] = 30'h210;
        tick();
        lsu_req_addr[1] = 30'h211;
        lsu_rsp_ready   = 1'b0;
        cache_rsp_valid = 1'b1;
        cache_rsp_tag   = 16'h0077;
        tick();
        lsu_req_valid   = '0;
        cache_rsp_valid = 1'b0;
        chk("prerst_state1", dbg_cache_state[1], BUF_FULL);
        chk("prerst_rsp_tag", lsu_rsp_tag, 16'h0077);
        reset = 1'b1;
        tick();
        chk("midrst_cache_valid", cache_req_valid, 4'b0000);
        chk("midrst_smem_valid", smem_req_valid, 4'b0000);
        chk("midrst_rsp_valid", lsu_rsp_valid, 1'b0);
        chk("midrst_state1", dbg_cache_state[1], BUF_EMPTY);
        reset           = 1'b0;
        cache_req_ready = '1;
        lsu_rsp_ready   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("postrst_cache_valid", cache_req_valid, 4'b0000);
            chk("postrst_rsp_valid", lsu_rsp_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
